// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//   Consumer stage for a T-flip-flop ripple counter. The raw counter bits are
//   brought into the clk domain by a two-flop synchronizer, then filtered until
//   STABLE_CYCLES+1 consecutive synchronized samples agree (or TIMEOUT SETTLE
//   edges elapse). The captured value is presented with its modular delta from
//   the previously accepted value, a wrap flag and a timeout flag, and held
//   under a valid/ready handshake.
//
// Ports:
//   clk         system clock, all state on rising edge
//   clear       asynchronous active-low reset
//   cnt_in      raw ripple counter outputs (asynchronous to clk)
//   sample_req  request one capture (only sampled in IDLE)
//   out_ready   consumer accepts the held result
//   cnt_out     captured count
//   delta       (cnt_out - last accepted value) mod 2^WIDTH
//   wrap        captured value < last accepted value
//   err         capture was forced by timeout
//   out_valid   result held and valid
//   busy        a capture is in progress or being held
module ripple_count_capture #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             sample_req,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] delta,
    output logic             wrap,
    output logic             err,
    output logic             out_valid,
    output logic             busy
);

    localparam int unsigned MW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] ref_val;
    logic [WIDTH-1:0] last_value;
    logic [MW-1:0]    match_cnt;
    logic [7:0]       settle_timer;
    logic             stable_hit;
    logic             timeout_hit;
    logic             capture;

    // Per-bit synchronizer; bits may resolve on different edges, which the
    // stability filter below absorbs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= cnt_in;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A stable match takes priority over a timeout on the same edge, so err
    // is set only when the filter never reached agreement.
    always_comb begin
        stable_hit  = (state == SETTLE) && (sync == ref_val) && (match_cnt == MATCH_LAST);
        timeout_hit = (state == SETTLE) && (settle_timer == TIMER_LAST);
        capture     = stable_hit || timeout_hit;
        state_next  = state;
        case (state)
            IDLE:    if (sample_req) state_next = SETTLE;
            SETTLE:  if (capture)    state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            ref_val      <= '0;
            match_cnt    <= '0;
            settle_timer <= '0;
            last_value   <= '0;
            cnt_out      <= '0;
            delta        <= '0;
            wrap         <= 1'b0;
            err          <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        ref_val      <= sync;
                        match_cnt    <= '0;
                        settle_timer <= '0;
                    end
                end
                SETTLE: begin
                    settle_timer <= settle_timer + 8'd1;
                    if (capture) begin
                        cnt_out   <= sync;
                        delta     <= sync - last_value;
                        wrap      <= (sync < last_value);
                        err       <= !stable_hit;
                        out_valid <= 1'b1;
                    end else if (sync == ref_val) begin
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        ref_val   <= sync;
                        match_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        last_value <= cnt_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture: table-driven static captures,
// hand-written glitch / timeout / reset sequences and randomized captures
// checked against a transaction-level model of the settle filter.
module tb_ripple_count_capture;

    localparam int W = 4;
    localparam int S = 2;
    localparam int T = 15;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] cnt_in;
    logic         sample_req;
    logic         out_ready;
    logic [W-1:0] cnt_out;
    logic [W-1:0] delta;
    logic         wrap;
    logic         err;
    logic         out_valid;
    logic         busy;

    ripple_count_capture #(
        .WIDTH(W),
        .STABLE_CYCLES(S),
        .TIMEOUT(T)
    ) dut (
        .clk(clk),
        .clear(clear),
        .cnt_in(cnt_in),
        .sample_req(sample_req),
        .out_ready(out_ready),
        .cnt_out(cnt_out),
        .delta(delta),
        .wrap(wrap),
        .err(err),
        .out_valid(out_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // cnt_in as seen at each rising edge, indexed by edge number.
    logic [W-1:0] drv[$];
    always @(posedge clk) drv.push_back(cnt_in);

    int           vectors = 0;
    int           miscompares = 0;
    int           rst_edge = 0;
    logic [W-1:0] model_last = '0;
    logic [W-1:0] seq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Synchronized value the DUT sees at edge n: cnt_in from two edges earlier,
    // or zero if those edges fall before reset release.
    function automatic logic [W-1:0] sync_at(input int n);
        if (n - 2 < rst_edge) return '0;
        return drv[n - 2];
    endfunction

    // Capture happens at the first edge e0+k whose synchronized value agrees
    // with the S preceding samples (back to e0); otherwise at e0+T with err.
    task automatic model_settle(input int e0, output int k, output logic [W-1:0] v, output logic e);
        for (int i = S; i <= T; i++) begin
            bit same = 1'b1;
            for (int j = i - S; j < i; j++)
                if (sync_at(e0 + j) != sync_at(e0 + i)) same = 1'b0;
            if (same) begin
                k = i; v = sync_at(e0 + i); e = 1'b0;
                return;
            end
        end
        k = T; v = sync_at(e0 + T); e = 1'b1;
    endtask

    task automatic hold_input(input logic [W-1:0] v);
        @(negedge clk);
        cnt_in = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_capture(input string name, input int ready_delay, input bit handshake,
                              input bit rand_ready, output logic [W-1:0] got_cnt,
                              output logic [W-1:0] got_delta, output logic got_wrap,
                              output logic got_err, output int got_lat);
        int           e0, k;
        bit           seen;
        logic [W-1:0] v, exp_delta;
        logic         e;
        got_lat = -1; got_cnt = '0; got_delta = '0; got_wrap = 1'b0; got_err = 1'b0;
        @(negedge clk);
        out_ready  = 1'b0;
        cnt_in     = seq[0];
        sample_req = 1'b1;
        e0 = drv.size();
        @(negedge clk);
        sample_req = 1'b0;
        check({name, "_busy_settle"}, busy, 1);
        seen = 1'b0;
        for (int i = 1; i <= T + 4; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            cnt_in = (i < seq.size()) ? seq[i] : seq[seq.size() - 1];
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!seen) begin
            check({name, "_capture_timeout_bound"}, 0, 1);
            return;
        end
        got_lat = drv.size() - 1 - e0;
        got_cnt = cnt_out; got_delta = delta; got_wrap = wrap; got_err = err;
        model_settle(e0, k, v, e);
        exp_delta = v - model_last;
        check({name, "_latency"}, got_lat, k);
        check({name, "_cnt_out"}, cnt_out, v);
        check({name, "_delta"}, delta, exp_delta);
        check({name, "_wrap"}, wrap, (v < model_last));
        check({name, "_err"}, err, e);
        check({name, "_busy_hold"}, busy, 1);
        out_ready = 1'b0;
        if (!handshake) return;
        for (int d = 0; d < ready_delay; d++) begin
            cnt_in     = W'($urandom);
            sample_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({name, "_hold_valid"}, out_valid, 1);
        end
        if (ready_delay > 0) begin
            check({name, "_hold_cnt_frozen"}, cnt_out, v);
            check({name, "_hold_delta_frozen"}, delta, exp_delta);
        end
        sample_req = 1'($urandom_range(0, 1));
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        sample_req = 1'b0;
        check({name, "_valid_after_accept"}, out_valid, 0);
        check({name, "_busy_after_accept"}, busy, 0);
        check({name, "_cnt_kept"}, cnt_out, v);
        model_last = v;
    endtask

    typedef struct {
        logic [W-1:0] value;
        int           ready_delay;
        logic [W-1:0] exp_cnt;
        logic [W-1:0] exp_delta;
        logic         exp_wrap;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] gc, gd;
        logic         gw, ge;
        int           gl;

        tbl[0] = '{4'h5,  0, 4'h5, 4'h5, 1'b0, 1'b0, 2};
        tbl[1] = '{4'hE, 10, 4'hE, 4'h9, 1'b0, 1'b0, 2};
        tbl[2] = '{4'h1,  1, 4'h1, 4'h3, 1'b1, 1'b0, 2};
        tbl[3] = '{4'h1,  0, 4'h1, 4'h0, 1'b0, 1'b0, 2};
        tbl[4] = '{4'h0,  2, 4'h0, 4'hF, 1'b1, 1'b0, 2};
        tbl[5] = '{4'h3,  0, 4'h3, 4'h3, 1'b0, 1'b0, 2};

        clear = 1'b0; cnt_in = '0; sample_req = 1'b0; out_ready = 1'b0;
        #3;
        check("reset_cnt_out", cnt_out, 0);
        check("reset_delta", delta, 0);
        check("reset_wrap", wrap, 0);
        check("reset_err", err, 0);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        clear = 1'b1;
        rst_edge = drv.size();
        model_last = '0;

        for (int r = 0; r < 6; r++) begin
            hold_input(tbl[r].value);
            seq = '{tbl[r].value};
            do_capture($sformatf("row%0d", r), tbl[r].ready_delay, 1'b1, 1'b0, gc, gd, gw, ge, gl);
            check($sformatf("row%0d_tbl_cnt", r), gc, tbl[r].exp_cnt);
            check($sformatf("row%0d_tbl_delta", r), gd, tbl[r].exp_delta);
            check($sformatf("row%0d_tbl_wrap", r), gw, tbl[r].exp_wrap);
            check($sformatf("row%0d_tbl_err", r), ge, tbl[r].exp_err);
            check($sformatf("row%0d_tbl_lat", r), gl, tbl[r].exp_lat);
        end

        // Glitch: 7 -> 6 -> 7 reaches the synchronized value mid-settle.
        hold_input(4'h7);
        seq = '{4'h6, 4'h7};
        do_capture("glitch", 1, 1'b1, 1'b0, gc, gd, gw, ge, gl);
        check("glitch_cnt", gc, 4'h7);
        check("glitch_err", ge, 0);
        check("glitch_lat", gl, 5);

        // Timeout: value changes on every edge through SETTLE.
        hold_input(4'h8);
        seq.delete();
        for (int i = 0; i < 20; i++) seq.push_back(W'(5 * i + 1));
        do_capture("timeout", 2, 1'b1, 1'b1, gc, gd, gw, ge, gl);
        check("timeout_err", ge, 1);
        check("timeout_cnt", gc, seq[13]);
        check("timeout_lat", gl, T);

        // Reset while settling.
        hold_input(4'h9);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        check("rst_settle_busy_before", busy, 1);
        #2 clear = 1'b0;
        #1;
        check("rst_settle_valid", out_valid, 0);
        check("rst_settle_busy", busy, 0);
        @(negedge clk);
        clear = 1'b1;
        rst_edge = drv.size();
        model_last = '0;

        // Reset while holding a result.
        hold_input(4'h9);
        seq = '{4'h9};
        do_capture("rst_hold_cap", 0, 1'b0, 1'b0, gc, gd, gw, ge, gl);
        #2 clear = 1'b0;
        #1;
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_busy", busy, 0);
        check("rst_hold_cnt", cnt_out, 0);
        @(negedge clk);
        clear = 1'b1;
        rst_edge = drv.size();
        model_last = '0;

        hold_input(4'h3);
        seq = '{4'h3};
        do_capture("post_reset", 0, 1'b1, 1'b0, gc, gd, gw, ge, gl);
        check("post_reset_delta", gd, 4'h3);
        check("post_reset_wrap", gw, 0);

        // Randomized captures against the model.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b, cur;
            int           len;
            a = W'($urandom);
            b = W'($urandom);
            len = $urandom_range(1, 18);
            cur = a;
            seq.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) cur = (cur == a) ? b : a;
                seq.push_back(cur);
            end
            if ($urandom_range(0, 3) == 0) begin
                seq.delete();
                for (int i = 0; i < 20; i++) seq.push_back(W'($urandom));
            end
            do_capture($sformatf("rand%0d", n), $urandom_range(0, 3), 1'b1, 1'b1, gc, gd, gw, ge, gl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Consumer stage directly downstream of the T-flip-flop ripple counter.
- Ripple counter bits settle asynchronously and glitch while the ripple propagates. This block brings the count into the clk domain and waits for the value to stop changing before capturing it.
- Reports each captured value with its modular delta from the previous capture, a wrap flag and a timeout error flag, through a valid/ready handshake.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- STABLE_CYCLES, 2, consecutive matching synchronized samples required before capture (>=1).
- TIMEOUT, 15, maximum SETTLE edges before forced capture (>STABLE_CYCLES, fits in 8 bits).

Ports:
- clk  input  1  system clock, all state on rising edge.
- clear  input  1  asynchronous active-low reset; clear=0 resets immediately.
- cnt_in  input  WIDTH  raw ripple counter outputs, asynchronous to clk.
- sample_req  input  1  request one capture; sampled only in IDLE.
- out_ready  input  1  consumer accepts the held result.
- cnt_out  output  WIDTH  captured count.
- delta  output  WIDTH  (cnt_out - last_value) mod 2^WIDTH.
- wrap  output  1  1 iff the captured value < last_value.
- err  output  1  1 iff the capture was forced by timeout.
- out_valid  output  1  result held and valid.
- busy  output  1  state != IDLE.

Behaviour:
- Synchronizer: two flops per bit on cnt_in; sync = second stage. There is no cross-bit coherence, so the stability filter is mandatory.
- Reset (clear=0): sync flops, ref, match_cnt, settle_timer, last_value, cnt_out, delta all 0; wrap=0, err=0, out_valid=0, state=IDLE, busy=0. Reset mid-SETTLE or mid-HOLD aborts silently; no result is emitted.
- FSM: IDLE, SETTLE, HOLD.
- IDLE: edge with sample_req=1 -> SETTLE; ref<=sync, match_cnt<=0, settle_timer<=0.
- SETTLE, every edge: settle_timer++.
  - If sync==ref and match_cnt==STABLE_CYCLES-1: capture sync, with err=0.
  - Else if sync==ref: match_cnt++.
  - Else: ref<=sync, match_cnt<=0.
  - If no capture and settle_timer==TIMEOUT-1: forced capture of current sync, with err=1.
  - A stable capture on the same edge as the timeout wins (err=0).
- Capture, single edge:
  - cnt_out<=v.
  - delta<=v-last_value, truncated to WIDTH bits.
  - wrap<=(v<last_value).
  - err as above.
  - out_valid<=1; state<=HOLD.
- Latency: with cnt_in static for >=2 edges before the sample_req edge E0, out_valid rises after edge E0+STABLE_CYCLES (E2 by default).
- HOLD:
  - Outputs frozen; sample_req ignored and not queued.
  - Edge with out_ready=1: out_valid<=0, last_value<=cnt_out, state<=IDLE.
  - cnt_out, delta, wrap and err keep their values after the handshake until the next capture.
  - sample_req and out_ready both high in HOLD: return to IDLE only; the requester must re-assert.
- out_ready is ignored when out_valid=0.
- First capture after reset: last_value=0, so delta=v and wrap=0.
- Wrap boundary: last=4'hE, v=4'h1 -> delta=4'h3, wrap=1. v==last -> delta=0, wrap=0.

Test Plan:
- Reset then static count: clear low then high, cnt_in=4'h5 held; sample_req pulse at E0 -> out_valid=1 after E2; cnt_out=5, delta=5, wrap=0, err=0; busy=1 E0..handshake.
- Sequential captures with wrap: capture 4'hE (accept), then cnt_in=4'h1, capture -> delta=4'h3, wrap=1; then 4'h1 again -> delta=0, wrap=0.
- Glitch rejection: during SETTLE, cnt_in toggles 7->6->7 for one clk each -> match_cnt restarts; final cnt_out=7, err=0; out_valid delayed by the restarts.
- Timeout: cnt_in changes every clk through SETTLE -> forced capture after 15 SETTLE edges, err=1, cnt_out = sync value at that edge.
- Backpressure: out_ready held 0 for 10 cycles while cnt_in changes -> cnt_out/delta unchanged, out_valid stays 1; sample_req pulses ignored; out_ready=1 -> IDLE next edge, out_valid=0.
- Async reset mid-operation: clear=0 mid-SETTLE and again mid-HOLD -> out_valid=0 and busy=0 immediately; next capture of 4'h3 gives delta=3 (last_value was reset).
